// File: rtl/gray_codec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gray_codec_pkg
// Description : Shared types, constants and Gray/binary conversion functions
//               for the gray_codec_stream symbol converter.
// Revision    : 1.0 - initial release
// ============================================================================
package gray_codec_pkg;

  // Width of the output handshake counter.
  localparam int CNT_W = 32;

  // Widest symbol the conversion functions handle (65536-point constellation).
  localparam int MAX_W = 16;

  // Per-beat conversion direction.
  typedef enum logic {
    MODE_G2B = 1'b0,
    MODE_B2G = 1'b1
  } mode_e;

  // Mask keeping only the low w bits of a MAX_W-wide word.
  function automatic logic [MAX_W-1:0] width_mask_f(input int w);
    logic [MAX_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Gray to binary on the low w bits: each binary bit is the running XOR
  // of all Gray bits from the MSB down to that position.
  function automatic logic [MAX_W-1:0] gray2bin_f(input logic [MAX_W-1:0] g,
                                                   input int w);
    logic [MAX_W-1:0] gm;
    logic [MAX_W-1:0] b;
    gm = g & width_mask_f(w);
    b  = '0;
    b[MAX_W-1] = gm[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ gm[i];
    end
    return b;
  endfunction

  // Binary to Gray on the low w bits.
  function automatic logic [MAX_W-1:0] bin2gray_f(input logic [MAX_W-1:0] b,
                                                   input int w);
    logic [MAX_W-1:0] bm;
    bm = b & width_mask_f(w);
    return bm ^ (bm >> 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/gray_codec_lane.sv
`default_nettype none
// ============================================================================
// Module      : gray_codec_lane
// Description : Combinational single-symbol Gray/binary converter. With
//               SPLIT_IQ set, the upper half (I axis) and lower half (Q axis)
//               of the symbol are coded independently.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_codec_lane
  import gray_codec_pkg::*;
#(
  parameter int W        = 4,
  parameter bit SPLIT_IQ = 1'b0
) (
  input  mode_e          mode,
  input  logic [W-1:0]   sym_in,
  output logic [W-1:0]   sym_out
);

  generate
    if (SPLIT_IQ) begin : g_split
      localparam int H = W / 2;

      logic [MAX_W-1:0] axis_i_ext;
      logic [MAX_W-1:0] axis_q_ext;

      // Convert the I and Q halves as two independent H-bit symbols.
      always_comb begin
        axis_i_ext = MAX_W'(sym_in[W-1:H]);
        axis_q_ext = MAX_W'(sym_in[H-1:0]);
        if (mode == MODE_B2G) begin
          sym_out = {H'(bin2gray_f(axis_i_ext, H)), H'(bin2gray_f(axis_q_ext, H))};
        end else begin
          sym_out = {H'(gray2bin_f(axis_i_ext, H)), H'(gray2bin_f(axis_q_ext, H))};
        end
      end
    end else begin : g_full
      logic [MAX_W-1:0] sym_ext;

      // Convert the whole W-bit symbol as one code word.
      always_comb begin
        sym_ext = MAX_W'(sym_in);
        if (mode == MODE_B2G) begin
          sym_out = W'(bin2gray_f(sym_ext, W));
        end else begin
          sym_out = W'(gray2bin_f(sym_ext, W));
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/gray_codec_stream.sv
`default_nettype none
// ============================================================================
// Module      : gray_codec_stream
// Description : Multi-lane pipelined Gray/binary symbol converter with an
//               elastic valid/ready stage chain, per-beat mode and an output
//               handshake counter.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_codec_stream
  import gray_codec_pkg::*;
#(
  parameter int MODULATION_ORDER = 16,
  parameter int NUM_LANES        = 1,
  parameter int PIPE_STAGES      = 2,
  parameter bit SPLIT_IQ         = 1'b0
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           i_mode,
  input  logic [NUM_LANES*$clog2(MODULATION_ORDER)-1:0]  i_data,
  input  logic                                           i_dv,
  output logic                                           i_rdy,
  output logic [NUM_LANES*$clog2(MODULATION_ORDER)-1:0]  o_data,
  output logic                                           o_mode,
  output logic                                           o_dv,
  input  logic                                           o_rdy,
  input  logic                                           i_clr,
  output logic [CNT_W-1:0]                               o_cnt
);

  localparam int W  = $clog2(MODULATION_ORDER);
  localparam int DW = NUM_LANES * W;

  // --------------------------------------------------------------------------
  // Configuration checks
  // --------------------------------------------------------------------------
  generate
    if (SPLIT_IQ && ((W % 2) != 0)) begin : g_chk_split_iq
      $fatal(1, "gray_codec_stream: SPLIT_IQ=1 needs an even symbol width");
    end
    if ((PIPE_STAGES < 1) || (PIPE_STAGES > 4)) begin : g_chk_pipe
      $fatal(1, "gray_codec_stream: PIPE_STAGES must be in 1..4");
    end
    if ((W < 1) || (W > MAX_W)) begin : g_chk_width
      $fatal(1, "gray_codec_stream: MODULATION_ORDER out of supported range");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Per-lane conversion ahead of stage 1
  // --------------------------------------------------------------------------
  logic [DW-1:0] conv_data;

  generate
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      gray_codec_lane #(
        .W        (W),
        .SPLIT_IQ (SPLIT_IQ)
      ) u_lane (
        .mode    (mode_e'(i_mode)),
        .sym_in  (i_data[k*W +: W]),
        .sym_out (conv_data[k*W +: W])
      );
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Elastic stage chain
  // --------------------------------------------------------------------------
  logic [PIPE_STAGES-1:0] stage_vld;
  logic [PIPE_STAGES-1:0] stage_mode;
  logic [DW-1:0]          stage_data [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] stage_load;

  // What each stage would capture: stage 0 takes the converted input,
  // later stages take their predecessor.
  logic                   src_vld  [PIPE_STAGES];
  logic                   src_mode [PIPE_STAGES];
  logic [DW-1:0]          src_data [PIPE_STAGES];

  assign src_vld[0]  = i_dv;
  assign src_mode[0] = i_mode;
  assign src_data[0] = conv_data;

  generate
    for (genvar s = 1; s < PIPE_STAGES; s++) begin : g_src
      assign src_vld[s]  = stage_vld[s-1];
      assign src_mode[s] = stage_mode[s-1];
      assign src_data[s] = stage_data[s-1];
    end
  endgenerate

  logic gap_seen;

  // A stage may load when downstream has room anywhere between it and the
  // output (an empty stage or o_rdy), so bubbles collapse before stalling.
  always_comb begin
    stage_load = '0;
    gap_seen   = o_rdy;
    for (int s = PIPE_STAGES - 1; s >= 0; s--) begin
      gap_seen      = gap_seen | ~stage_vld[s];
      stage_load[s] = gap_seen;
    end
  end

  assign i_rdy = stage_load[0];

  // Advance the chain; payload only updates on a real beat so the last
  // output value is held while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_vld  <= '0;
      stage_mode <= '0;
      for (int s = 0; s < PIPE_STAGES; s++) begin
        stage_data[s] <= '0;
      end
    end else begin
      for (int s = 0; s < PIPE_STAGES; s++) begin
        if (stage_load[s]) begin
          stage_vld[s] <= src_vld[s];
          if (src_vld[s]) begin
            stage_data[s] <= src_data[s];
            stage_mode[s] <= src_mode[s];
          end
        end
      end
    end
  end

  assign o_dv   = stage_vld[PIPE_STAGES-1];
  assign o_mode = stage_mode[PIPE_STAGES-1];
  assign o_data = stage_data[PIPE_STAGES-1];

  // --------------------------------------------------------------------------
  // Output handshake counter
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt;

  // Count output transfers; a clear overrides a coincident transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (i_clr) begin
      cnt <= '0;
    end else if (o_dv && o_rdy) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign o_cnt = cnt;

endmodule
`default_nettype wire

// File: tb/tb_gray_codec_stream.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_gray_codec_stream
// Description : Self-checking bench for gray_codec_stream (4-lane main
//               instance plus a single-lane split-I/Q instance).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_codec_stream;

  localparam int P    = 2;
  localparam int NL   = 4;
  localparam int W    = 4;
  localparam int DW   = NL * W;
  localparam int P_IQ = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_mode = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          i_dv = 1'b0;
  logic          i_rdy;
  logic [DW-1:0] o_data;
  logic          o_mode;
  logic          o_dv;
  logic          o_rdy = 1'b1;
  logic          i_clr = 1'b0;
  logic [31:0]   o_cnt;

  logic          iq_mode = 1'b0;
  logic [W-1:0]  iq_data = '0;
  logic          iq_dv = 1'b0;
  logic          iq_rdy;
  logic [W-1:0]  iq_o_data;
  logic          iq_o_mode;
  logic          iq_o_dv;
  logic [31:0]   iq_o_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic lat_chk = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gray_codec_stream #(
    .MODULATION_ORDER (16), .NUM_LANES (NL), .PIPE_STAGES (P), .SPLIT_IQ (1'b0)
  ) dut (
    .clk (clk), .rst (rst), .i_mode (i_mode), .i_data (i_data), .i_dv (i_dv),
    .i_rdy (i_rdy), .o_data (o_data), .o_mode (o_mode), .o_dv (o_dv),
    .o_rdy (o_rdy), .i_clr (i_clr), .o_cnt (o_cnt)
  );

  gray_codec_stream #(
    .MODULATION_ORDER (16), .NUM_LANES (1), .PIPE_STAGES (P_IQ), .SPLIT_IQ (1'b1)
  ) dut_iq (
    .clk (clk), .rst (rst), .i_mode (iq_mode), .i_data (iq_data), .i_dv (iq_dv),
    .i_rdy (iq_rdy), .o_data (iq_o_data), .o_mode (iq_o_mode), .o_dv (iq_o_dv),
    .o_rdy (1'b1), .i_clr (1'b0), .o_cnt (iq_o_cnt)
  );

  // ---------------- reference model ----------------
  // Binary bit i is the parity of all Gray bits at positions >= i.
  function automatic logic [W-1:0] ref_g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    for (int i = 0; i < W; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  function automatic logic [W-1:0] ref_b2g(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [DW-1:0] ref_beat(input logic [DW-1:0] d, input logic m);
    logic [DW-1:0] r;
    for (int k = 0; k < NL; k++) begin
      r[k*W +: W] = m ? ref_b2g(d[k*W +: W]) : ref_g2b(d[k*W +: W]);
    end
    return r;
  endfunction

  typedef struct {
    logic [DW-1:0] data;
    logic          mode;
    int            cyc;
  } beat_t;

  beat_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- cycle-by-cycle compare ----------------
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;
  logic          prev_mode  = 1'b0;

  always @(negedge clk) begin
    beat_t h;
    if (!rst) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      chk("i_rdy", i_rdy, !((q.size() == P) && !o_rdy));
      if (q.size() == 0) chk("idle_dv", o_dv, 1'b0);
      if (prev_stall) begin
        chk("stall_dv", o_dv, 1'b1);
        chk("stall_data", o_data, prev_data);
        chk("stall_mode", o_mode, prev_mode);
      end
      if (o_dv && o_rdy && (q.size() != 0)) begin
        h = q.pop_front();
        chk("out_data", o_data, h.data);
        chk("out_mode", o_mode, h.mode);
        if (lat_chk) chk("latency", cyc - h.cyc, P);
      end
      if (i_dv && i_rdy) begin
        h.data = ref_beat(i_data, i_mode);
        h.mode = i_mode;
        h.cyc  = cyc;
        q.push_back(h);
      end
      prev_stall = o_dv && !o_rdy;
      prev_data  = o_data;
      prev_mode  = o_mode;
    end
  end

  // ---------------- directed helpers ----------------
  task automatic send_one(input logic [DW-1:0] d, input logic m, input logic [DW-1:0] exp,
                          input logic clr, input logic [31:0] exp_cnt);
    int n = 0;
    i_data = d; i_mode = m; i_dv = 1'b1; o_rdy = 1'b1;
    while (n < 10) begin
      @(posedge clk); #1;
      n++;
      i_dv = 1'b0;
      if (o_dv) break;
    end
    chk("lat_direct", n, P);
    chk("data_direct", o_data, exp);
    chk("mode_direct", o_mode, m);
    i_clr = clr;
    @(posedge clk); #1;
    i_clr = 1'b0;
    chk("cnt_direct", o_cnt, exp_cnt);
    chk("idle_hold", o_data, exp);
    chk("idle_dv_direct", o_dv, 1'b0);
  endtask

  task automatic send_iq(input logic [W-1:0] d, input logic m, input logic [W-1:0] exp);
    int n = 0;
    iq_data = d; iq_mode = m; iq_dv = 1'b1;
    while (n < 10) begin
      @(posedge clk); #1;
      n++;
      iq_dv = 1'b0;
      if (iq_o_dv) break;
    end
    chk("iq_lat", n, P_IQ);
    chk("iq_data", iq_o_data, exp);
    chk("iq_mode", iq_o_mode, m);
    @(posedge clk); #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int rdy_low;
    int acc;
    int guard;
    int dv_seen;
    logic took;

    // Reset state
    #12;
    chk("rst_o_dv", o_dv, 1'b0);
    chk("rst_o_data", o_data, '0);
    chk("rst_o_mode", o_mode, 1'b0);
    chk("rst_o_cnt", o_cnt, '0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rdy_after_rst", i_rdy, 1'b1);

    // Directed conversions: lanes {F,1,7,A} G2B -> {A,1,5,C}; {F,8,3,B} B2G -> {8,C,2,E}
    send_one(16'hF17A, 1'b0, 16'hA15C, 1'b0, 32'd1);
    send_one(16'hF83B, 1'b1, 16'h8C2E, 1'b0, 32'd2);

    // Clear while idle
    i_clr = 1'b1;
    @(posedge clk); #1;
    i_clr = 1'b0;
    chk("clr_idle", o_cnt, 32'd0);

    // Split I/Q instance
    chk("iq_rdy", iq_rdy, 1'b1);
    send_iq(4'b1010, 1'b0, 4'b1111);
    send_iq(4'b1011, 1'b1, 4'b1110);
    send_iq(4'b0110, 1'b0, 4'b0111);
    send_iq(4'b1001, 1'b1, 4'b1101);
    chk("iq_cnt", iq_o_cnt, 32'd4);

    // Full-rate stream, random data and mode, no backpressure
    rdy_low = 0;
    o_rdy = 1'b1;
    for (int i = 0; i < 64; i++) begin
      i_data = DW'($urandom);
      i_mode = 1'($urandom);
      i_dv   = 1'b1;
      if (!i_rdy) rdy_low++;
      @(posedge clk); #1;
    end
    i_dv = 1'b0;
    repeat (P + 2) @(posedge clk);
    #1;
    chk("stream_rdy_low", rdy_low, 0);
    chk("stream_cnt", o_cnt, 32'd64);

    // Random backpressure with continuous input
    lat_chk = 1'b0;
    acc = 0; guard = 0;
    i_data = DW'($urandom); i_mode = 1'($urandom); i_dv = 1'b1;
    while (acc < 100 && guard < 2000) begin
      o_rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      took = i_dv && i_rdy;
      if (took) acc++;
      @(posedge clk); #1;
      guard++;
      if (took) begin
        i_data = DW'($urandom);
        i_mode = 1'($urandom);
      end
    end
    i_dv = 1'b0;
    o_rdy = 1'b1;
    chk("rand_accepted", acc, 100);
    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("rand_drained", q.size(), 0);
    chk("rand_cnt", o_cnt, 32'd164);

    // Reset with two beats in flight
    i_data = 16'h1234; i_mode = 1'b0; i_dv = 1'b1; o_rdy = 1'b1;
    @(posedge clk); #1;
    i_data = 16'h5678;
    @(posedge clk); #1;
    i_dv = 1'b0; o_rdy = 1'b0;
    chk("pre_rst_dv", o_dv, 1'b1);
    rst = 1'b0;
    #1;
    chk("midrst_dv", o_dv, 1'b0);
    chk("midrst_cnt", o_cnt, 32'd0);
    chk("midrst_data", o_data, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1; o_rdy = 1'b1;
    dv_seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (o_dv) dv_seen++;
    end
    chk("no_stale_beat", dv_seen, 0);
    chk("cnt_after_rst", o_cnt, 32'd0);

    // Clear coincident with a handshake
    lat_chk = 1'b1;
    send_one(16'h0000, 1'b1, 16'h0000, 1'b0, 32'd1);
    send_one(16'hFFFF, 1'b0, 16'hAAAA, 1'b1, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gray_codec_stream.md
Name: gray_codec_stream

Overview:
- Multi-lane, pipelined Gray/binary symbol converter for the modem datapath, placed between the slicer/demapper and the bit-level stages.
- Each beat is converted in one of two modes: Gray-to-binary or binary-to-Gray. The mode is selected per beat.
- Optional per-axis (I/Q) Gray coding for square QAM.
- Elastic valid/ready pipeline with full throughput, backpressure and a beat counter.

Parameters:
- MODULATION_ORDER, 16, constellation size; W = $clog2(MODULATION_ORDER) bits per symbol.
- NUM_LANES, 1, symbols per beat, converted in parallel.
- PIPE_STAGES, 2, register stages and latency (legal 1..4).
- SPLIT_IQ, 0, 1 = code the upper W/2 bits (I) and lower W/2 bits (Q) independently; W must be even.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- i_mode  input  1  0 = Gray-to-binary, 1 = binary-to-Gray; qualified by i_dv
- i_data  input  NUM_LANES*W  lane k at bits [k*W +: W]
- i_dv  input  1  input beat valid
- i_rdy  output  1  block can accept a beat
- o_data  output  NUM_LANES*W  converted symbols
- o_mode  output  1  mode that travelled with the beat
- o_dv  output  1  output beat valid
- o_rdy  input  1  downstream accepts
- i_clr  input  1  synchronous clear of o_cnt
- o_cnt  output  32  count of output handshakes (o_dv && o_rdy)

Behaviour:
- Reset (rst=0, async):
  - All stage valid flags, o_dv, o_data, o_mode and o_cnt are cleared to 0.
  - i_rdy=1 from the first edge after release.
  - Asserting reset mid-operation discards all in-flight beats; no partial beat is emitted.
- Conversion (per lane, combinational ahead of stage 1):
  - Gray-to-binary: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i].
  - Binary-to-Gray: g = b ^ (b>>1).
  - With SPLIT_IQ=1, each formula is applied separately on bits [W-1:W/2] and [W/2-1:0].
- Elaboration checks:
  - SPLIT_IQ=1 with odd W is a fatal error.
  - PIPE_STAGES outside 1..4 is a fatal error.
- Handshake:
  - Input beat accepted when i_dv && i_rdy.
  - Output beat transferred when o_dv && o_rdy.
  - i_dv does not depend on i_rdy.
- Pipeline:
  - Each stage holds a valid bit plus data and mode.
  - Stage s loads when it is empty or its content moves to stage s+1 (or out) in the same cycle.
  - i_rdy = stage1 empty OR stage1 advancing; it is combinational from registers and o_rdy only, with no path from i_dv.
- Latency and throughput:
  - Latency is exactly PIPE_STAGES cycles, from the accepting edge to o_dv=1, when o_rdy is held 1.
  - One beat per cycle sustained.
- Backpressure:
  - While o_dv=1 and o_rdy=0, o_data and o_mode hold stable.
  - Bubbles compress: stages fill before i_rdy drops.
  - i_rdy=0 only when all PIPE_STAGES stages are full and o_rdy=0.
- Mode changes between consecutive beats take effect per beat, with no flush and no bubble.
- Counter:
  - o_cnt increments by 1 per output handshake and wraps from 0xFFFFFFFF to 0.
  - i_clr=1 forces 0 on the next edge; clear wins over a simultaneous handshake.
- Idle output: o_data keeps its last value when o_dv=0 and is not zeroed.

Decomposition:
- Package gray_codec_pkg holds:
  - mode enum: MODE_G2B=0, MODE_B2G=1.
  - Functions gray2bin_f(g, w) and bin2gray_f(b, w).
  - Constant CNT_W=32.
- Sub-module gray_codec_lane: combinational single-symbol converter (mode, SPLIT_IQ), instantiated NUM_LANES times.
- The elastic stage chain lives in the top module.

Test Plan:
- Defaults (M=16, SPLIT_IQ=0), mode 0, i_data=4'b1010 -> o_data=4'b1100 after 2 cycles; o_cnt=1.
- SPLIT_IQ=1, mode 0, 4'b1010 -> 4'b1111. Mode 1, 4'b1011 -> 4'b1110, the same result as with SPLIT_IQ=0.
- NUM_LANES=4, 64 beats of random data with random mode, o_rdy=1 -> output stream matches the reference model with latency PIPE_STAGES; i_rdy stays 1; o_cnt=64.
- Random o_rdy (50%) with continuous i_dv -> no loss or duplication, o_data stable while stalled, i_rdy=0 only with all stages full.
- Reset pulse with 2 beats in flight -> o_dv=0 immediately; no stale beat after release; o_cnt=0.
- o_cnt preloaded via 2^32-1 handshakes (or a forced value) -> wraps to 0. i_clr coincident with a handshake -> o_cnt=0.
